// File: rtl/instr_prefetch_queue.sv
// Prefetch queue between a handshaked instruction memory and the IF/ID register.
// Optional same-cycle response bypass to decode is enabled by defining PREFETCH_BYPASS_EN.
module instr_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata,
   output logic                     instr_valid,
   output logic [31:0]              instr,
   output logic [31:0]              instr_pc4,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = CW + 1;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] r_occ;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [31:0]   r_q_instr [DEPTH];
   logic [31:0]   r_q_pc4   [DEPTH];

   logic [SW-1:0] w_inflight;
   logic          w_credit;
   logic          w_fire;
   logic          w_drop;
   logic          w_accept;
   logic          w_head_valid;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_resp_pc4;

   // Credit counts both queued entries and requests still in flight, so a push never overflows.
   assign w_inflight   = SW'(r_occ) + SW'(r_outstanding);
   assign w_credit     = (w_inflight < SW'(DEPTH));
   assign w_fire       = imem_req & imem_gnt;
   assign w_drop       = imem_rvalid & (r_discard != '0);
   assign w_accept     = imem_rvalid & ~w_drop;
   assign w_head_valid = (r_occ != '0);
   assign w_resp_pc4   = r_resp_pc + 32'd4;

`ifdef PREFETCH_BYPASS_EN
   assign w_bypass = ~reset & ~w_head_valid & imem_rvalid & (r_discard == '0)
                   & instr_ready & enable & ~redirect;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_accept & ~w_bypass & ~redirect;
   assign w_pop  = enable & w_head_valid & instr_ready & ~redirect;

   assign imem_req  = ~reset & enable & ~redirect & w_credit;
   assign imem_addr = r_fetch_pc;

   always_comb begin
      instr_valid = w_head_valid | w_bypass;
      instr       = '0;
      instr_pc4   = '0;
      if (w_bypass) begin
         instr     = imem_rdata;
         instr_pc4 = w_resp_pc4;
      end else if (w_head_valid) begin
         instr     = r_q_instr[r_rd_ptr];
         instr_pc4 = r_q_pc4[r_rd_ptr];
      end
   end

   assign occupancy = r_occ;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_occ         <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
      end else if (redirect) begin
         // Every response still owed after this cycle belongs to the abandoned path.
         r_fetch_pc    <= redirect_pc;
         r_resp_pc     <= redirect_pc;
         r_outstanding <= r_outstanding - CW'(imem_rvalid);
         r_discard     <= r_outstanding - CW'(imem_rvalid);
         r_occ         <= '0;
         r_rd_ptr      <= r_wr_ptr;
      end else begin
         if (w_fire) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         r_outstanding <= r_outstanding + CW'(w_fire) - CW'(imem_rvalid);
         if (w_drop) begin
            r_discard <= r_discard - CW'(1);
         end
         if (w_accept) begin
            r_resp_pc <= w_resp_pc4;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
      end
   end

   // NOTE: queue storage has no reset; outputs are gated by occupancy so stale words are never visible.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_instr[r_wr_ptr] <= imem_rdata;
         r_q_pc4[r_wr_ptr]   <= w_resp_pc4;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue (DEPTH=4, RESET_PC=0, default build).
module tb_instr_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc4;
   logic        instr_ready;
   logic [2:0]  occupancy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .enable(enable), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc4(instr_pc4),
      .instr_ready(instr_ready), .occupancy(occupancy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic rdr, input logic [31:0] rpc,
                        input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic rdy);
      enable      = en;
      redirect    = rdr;
      redirect_pc = rpc;
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rd;
      instr_ready = rdy;
   endtask

   initial begin
      reset = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      #1;
      check("rst_req",   32'(imem_req), 32'd0);
      check("rst_addr",  imem_addr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc4",   instr_pc4, 32'h0);
      check("rst_occ",   32'(occupancy), 32'd0);

      // Sequential fetch with ready=1
      tick(); reset = 1'b0;
      drive(1, 0, 0, 1, 0, 0, 1); #1;
      check("t1_req0",  32'(imem_req), 32'd1);
      check("t1_addr0", imem_addr, 32'h0);
      tick(); drive(1, 0, 0, 1, 1, 32'hD000_0000, 1); #1;
      check("t1_addr1", imem_addr, 32'h4);
      check("t1_nv",    32'(instr_valid), 32'd0);
      tick(); drive(1, 0, 0, 1, 1, 32'hD000_0001, 1); #1;
      check("t1_addr2", imem_addr, 32'h8);
      check("t1_i0",    instr, 32'hD000_0000);
      check("t1_p0",    instr_pc4, 32'h4);
      check("t1_occ0",  32'(occupancy), 32'd1);
      tick(); drive(1, 0, 0, 0, 1, 32'hD000_0002, 1); #1;
      check("t1_i1",    instr, 32'hD000_0001);
      check("t1_p1",    instr_pc4, 32'h8);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t1_i2",    instr, 32'hD000_0002);
      check("t1_p2",    instr_pc4, 32'hC);
      check("t1_occ2",  32'(occupancy), 32'd1);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t1_empty", 32'(instr_valid), 32'd0);
      check("t1_occe",  32'(occupancy), 32'd0);

      // Fill to DEPTH with ready=0, then drain
      tick(); drive(1, 0, 0, 1, 0, 0, 0); #1;
      check("t2_addr0", imem_addr, 32'hC);
      tick(); drive(1, 0, 0, 1, 1, 32'hE000_0000, 0); #1;
      check("t2_req1",  32'(imem_req), 32'd1);
      tick(); drive(1, 0, 0, 1, 1, 32'hE000_0001, 0); #1;
      check("t2_req2",  32'(imem_req), 32'd1);
      tick(); drive(1, 0, 0, 1, 1, 32'hE000_0002, 0); #1;
      check("t2_req3",  32'(imem_req), 32'd1);
      check("t2_addr3", imem_addr, 32'h18);
      tick(); drive(1, 0, 0, 1, 1, 32'hE000_0003, 0); #1;
      check("t2_full_req", 32'(imem_req), 32'd0);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t2_req_off", 32'(imem_req), 32'd0);
      check("t2_occ4",    32'(occupancy), 32'd4);
      check("t2_i0",      instr, 32'hE000_0000);
      check("t2_p0",      instr_pc4, 32'h10);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t2_i1",  instr, 32'hE000_0001);
      check("t2_p1",  instr_pc4, 32'h14);
      check("t2_occ3", 32'(occupancy), 32'd3);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t2_i2",  instr, 32'hE000_0002);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t2_i3",  instr, 32'hE000_0003);
      check("t2_p3",  instr_pc4, 32'h1C);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t2_drained", 32'(occupancy), 32'd0);
      check("t2_addr_end", imem_addr, 32'h1C);

      // Redirect with two requests in flight
      tick(); drive(1, 0, 0, 1, 0, 0, 1);
      tick(); drive(1, 0, 0, 1, 0, 0, 1);
      tick(); drive(1, 1, 32'h100, 0, 0, 0, 1); #1;
      check("t3_req_rdr", 32'(imem_req), 32'd0);
      tick(); drive(1, 0, 0, 0, 1, 32'hBAD0_0000, 1); #1;
      check("t3_addr",    imem_addr, 32'h100);
      check("t3_req",     32'(imem_req), 32'd1);
      tick(); drive(1, 0, 0, 1, 1, 32'hBAD0_0001, 1); #1;
      check("t3_drop0",   32'(instr_valid), 32'd0);
      tick(); drive(1, 0, 0, 0, 1, 32'hC000_0100, 1); #1;
      check("t3_drop1",   32'(instr_valid), 32'd0);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t3_valid",   32'(instr_valid), 32'd1);
      check("t3_instr",   instr, 32'hC000_0100);
      check("t3_pc4",     instr_pc4, 32'h104);
      check("t3_occ",     32'(occupancy), 32'd1);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t3_empty",   32'(occupancy), 32'd0);

      // Redirect coinciding with a response and a would-be pop
      tick(); drive(1, 0, 0, 1, 0, 0, 1);
      tick(); drive(1, 0, 0, 1, 1, 32'hF000_0000, 1);
      tick(); drive(1, 1, 32'h200, 0, 1, 32'hF000_0001, 1); #1;
      check("t4_head",    instr, 32'hF000_0000);
      check("t4_req_rdr", 32'(imem_req), 32'd0);
      tick(); drive(1, 0, 0, 1, 0, 0, 1); #1;
      check("t4_valid",   32'(instr_valid), 32'd0);
      check("t4_occ",     32'(occupancy), 32'd0);
      check("t4_addr",    imem_addr, 32'h200);
      tick(); drive(1, 0, 0, 0, 1, 32'hD000_0200, 1);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t4_next_i",  instr, 32'hD000_0200);
      check("t4_next_p",  instr_pc4, 32'h204);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t4_empty",   32'(occupancy), 32'd0);

      // enable low with two requests in flight
      tick(); drive(1, 0, 0, 1, 0, 0, 0);
      tick(); drive(1, 0, 0, 1, 0, 0, 0);
      tick(); drive(0, 0, 0, 1, 1, 32'h6000_0000, 1); #1;
      check("t5_req_off0", 32'(imem_req), 32'd0);
      tick(); drive(0, 0, 0, 0, 1, 32'h6000_0001, 1); #1;
      check("t5_req_off1", 32'(imem_req), 32'd0);
      check("t5_head0",    instr, 32'h6000_0000);
      tick(); drive(0, 0, 0, 0, 0, 0, 1); #1;
      check("t5_occ2",     32'(occupancy), 32'd2);
      check("t5_head",     instr, 32'h6000_0000);
      check("t5_pc4",      instr_pc4, 32'h208);
      check("t5_frozen",   imem_addr, 32'h20C);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t5_still",    instr, 32'h6000_0000);
      check("t5_req_on",   32'(imem_req), 32'd1);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t5_i1",       instr, 32'h6000_0001);
      check("t5_p1",       instr_pc4, 32'h20C);
      check("t5_occ1",     32'(occupancy), 32'd1);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t5_empty",    32'(occupancy), 32'd0);

      // Reset mid-stream with three entries queued
      tick(); drive(1, 0, 0, 1, 0, 0, 0);
      tick(); drive(1, 0, 0, 1, 1, 32'h7000_0000, 0);
      tick(); drive(1, 0, 0, 1, 1, 32'h7000_0001, 0);
      tick(); drive(1, 0, 0, 0, 1, 32'h7000_0002, 0);
      tick(); drive(1, 0, 0, 0, 0, 0, 0); #1;
      check("t6_occ3",     32'(occupancy), 32'd3);
      check("t6_addr_pre", imem_addr, 32'h218);
      reset = 1'b1; #1;
      check("t6_req",   32'(imem_req), 32'd0);
      check("t6_addr",  imem_addr, 32'h0);
      check("t6_valid", 32'(instr_valid), 32'd0);
      check("t6_instr", instr, 32'h0);
      check("t6_pc4",   instr_pc4, 32'h0);
      check("t6_occ",   32'(occupancy), 32'd0);
      tick(); reset = 1'b0;
      drive(1, 0, 0, 1, 0, 0, 1); #1;
      check("t6_restart_addr", imem_addr, 32'h0);
      check("t6_restart_req",  32'(imem_req), 32'd1);
      tick(); drive(1, 0, 0, 0, 1, 32'h8000_0000, 1);
      tick(); drive(1, 0, 0, 0, 0, 0, 1); #1;
      check("t6_restart_i", instr, 32'h8000_0000);
      check("t6_restart_p", instr_pc4, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
